mc_datamem: RTL and testbench
=============================

MC_DATAMEM -- requirements
Module: mc_datamem

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal range 1..15, cycles from request acceptance to the ready pulse.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  access request, sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-008 uns  input  1  load zero-extends when 1, sign-extends when 0 (lbu/lhu vs lb/lh).
REQ-009 addr  input  32  byte address; bits [ADDR_W+1:0] used, upper bits ignored (wrap).
REQ-010 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 busy  output  1  high from the cycle after acceptance until the ready cycle inclusive.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 rdata  output  32  load result, valid only while ready=1 with we=0, else 0.
REQ-014 err  output  1  misaligned-access flag, valid with ready (macro-dependent, see Configuration).

Function
REQ-015 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-016 IDLE & req=1 -> latch we/size/uns/addr/wdata, load counter with LATENCY-1, go WAIT (LATENCY>1) or DONE (LATENCY=1).
REQ-017 WAIT decrements counter each cycle; at counter 1 goes DONE.
REQ-018 DONE asserts ready for exactly one cycle, then returns IDLE; ready rises exactly LATENCY cycles after the acceptance edge.
REQ-019 req while busy is ignored; no queueing; a new request is accepted earliest in the cycle after ready.
REQ-020 Inputs changing after acceptance have no effect on the access in flight.
REQ-021 Store commits at the DONE edge only, using byte enables: byte -> 1 lane selected by addr[1:0]; half -> 2 lanes by addr[1]; word -> 4 lanes.
REQ-022 Load reads the full word, selects lane(s) by addr[1:0]/addr[1], extends per uns to 32 bits.
REQ-023 Store followed immediately by load of the same word returns the newly written data.
REQ-024 Memory array contents are not reset; rdata for never-written locations is undefined for the bench.

Reset
REQ-025 clrn low forces immediately: state IDLE, counter 0, busy 0, ready 0, rdata 0, err 0.
REQ-026 clrn asserted mid-access aborts it; a pending store is not committed; memory otherwise unchanged.
REQ-027 First request is accepted at the first rising edge with clrn high and req high.

Configuration
REQ-028 Macro MC_DATAMEM_MISALIGN_CHECK_EN.
REQ-029 Defined: half with addr[0]=1 or word with addr[1:0]!=00 completes with normal latency, err=1 on the ready cycle, no memory write, rdata=0.
REQ-030 Not defined: err tied 0; low address bits below the access size are forced to zero (access aligned down).

Verification
REQ-031 LATENCY=2: sw addr 0x10 wdata 0xDEADBEEF, then lw 0x10 -> ready 2 cycles after each acceptance, rdata 0xDEADBEEF.
REQ-032 sb 0x13 wdata 0x80 over word 0x00000000; lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80000000.
REQ-033 sh 0x22 wdata 0x1234 then lh 0x22 -> 0x00001234; req held high during busy -> exactly one ready per accepted request.
REQ-034 Store accepted, clrn pulsed low one cycle later -> no ready, lw of that address returns previous value.
REQ-035 With macro: lw 0x11 -> err=1, rdata 0; without macro: lw 0x11 returns word at 0x10, err 0.
REQ-036 LATENCY=1 and LATENCY=15 builds: back-to-back requests -> ready spacing LATENCY+1 cycles.

Source files
------------

// File: rtl/mc_datamem.sv
`default_nettype none
// ============================================================================
// Module   : mc_datamem
// Purpose  : Word-organised data memory with a fixed-latency request/ready
//            handshake. It supports byte, halfword and word loads and stores,
//            and loads are sign- or zero-extended.
// Ports    : clk            single clock, rising edge
//            clrn           asynchronous active-low reset
//            req/we/size/uns/addr/wdata
//                           request, sampled only while idle
//            busy           high from the cycle after acceptance through ready
//            ready          one-cycle completion pulse
//            rdata          load result, zero when not a completing load
//            err            misaligned-access flag, valid with ready
// Config   : `define MC_DATAMEM_MISALIGN_CHECK_EN makes a misaligned
//            half/word access report err and skip the memory access.
//            When the macro is undefined, such an access is aligned down.
// Revision : 1.0 - initial release
// ============================================================================
module mc_datamem #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         c_depth    = 1 << ADDR_W;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;
    localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

    logic [1:0]        r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              w_accept;

    logic              r_we, r_uns;
    logic [1:0]        r_size;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [31:0]       r_mem [0:c_depth-1];

    logic              w_is_byte, w_is_half;
    logic              w_fault;
    logic [1:0]        w_lane;
    logic [ADDR_W-1:0] w_index;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ld;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;

    // Address bits above the array are ignored, so accesses wrap.
    generate
        if (ADDR_W + 2 < 32) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^addr[31:ADDR_W+2];
        end
    endgenerate

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = c_cnt_init;
                    w_state_nxt = (LATENCY == 1) ? c_st_done : c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Request fields are captured once at acceptance. Later input changes
    // therefore have no effect on the access in flight.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= we;
            r_uns   <= uns;
            r_size  <= size;
            r_addr  <= addr[ADDR_W+1:0];
            r_wdata <= wdata;
        end
    end

    // ------------------------------------------------------ access decode
    assign w_is_byte = (r_size == 2'b00);
    assign w_is_half = (r_size == 2'b01);   // 1x and 11 are both word

`ifdef MC_DATAMEM_MISALIGN_CHECK_EN
    assign w_fault = (w_is_half & r_addr[0]) | (r_size[1] & (r_addr[1:0] != 2'b00));
    assign w_lane  = r_addr[1:0];
`else
    assign w_fault = 1'b0;
    // Drop the offset bits that lie below the access size.
    assign w_lane  = {r_addr[1] & ~r_size[1], r_addr[0] & w_is_byte};
`endif

    assign w_index = r_addr[ADDR_W+1:2];
    assign w_word  = r_mem[w_index];
    assign w_byte  = w_word[{w_lane, 3'b000} +: 8];
    assign w_half  = w_word[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_ld = w_word;
        if (w_is_byte)
            w_ld = {{24{~r_uns & w_byte[7]}}, w_byte};
        else if (w_is_half)
            w_ld = {{16{~r_uns & w_half[15]}}, w_half};
    end

    // Store data is replicated across lanes, and the byte enables pick the
    // destination lane or lanes.
    always_comb begin
        w_be = 4'b1111;
        w_wd = r_wdata;
        if (w_is_byte) begin
            w_be = 4'b0001 << w_lane;
            w_wd = {4{r_wdata[7:0]}};
        end else if (w_is_half) begin
            w_be = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wd = {2{r_wdata[15:0]}};
        end
    end

    // The store commits on the edge that leaves DONE. A reset clears the
    // state asynchronously, so an aborted store never reaches this write.
    always_ff @(posedge clk) begin
        if ((r_state == c_st_done) && r_we && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_index][8*i +: 8] <= w_wd[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign busy  = (r_state != c_st_idle);
    assign ready = (r_state == c_st_done);
    assign rdata = (ready && !r_we && !w_fault) ? w_ld : 32'd0;
    assign err   = ready & w_fault;

endmodule
`default_nettype wire

// File: tb/tb_mc_datamem.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_datamem
// Purpose  : Self-checking bench for mc_datamem. A byte-addressed reference
//            memory predicts load results. The bench also checks latency,
//            back-to-back spacing (LATENCY 2, 1 and 15), the reset abort and
//            misaligned handling. Defining MC_DATAMEM_MISALIGN_CHECK_EN
//            selects the expected misalign behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_datamem;

    localparam int          ADDR_W  = 10;
    localparam int          LAT     = 2;
    localparam int          DEPTHB  = 4 << ADDR_W;
    localparam logic [31:0] c_amask = 32'(DEPTHB - 1);

    logic        clk, clrn, req, req1, req15, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, ready, err;
    logic [31:0] rdata;
    logic        busy1, ready1, err1, busy15, ready15, err15;
    logic [31:0] rdata1, rdata15;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mb [0:DEPTHB-1];

    mc_datamem #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .clrn(clrn), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy), .ready(ready), .rdata(rdata), .err(err));

    mc_datamem #(.ADDR_W(ADDR_W), .LATENCY(1)) dut_l1 (
        .clk(clk), .clrn(clrn), .req(req1), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy1), .ready(ready1), .rdata(rdata1), .err(err1));

    mc_datamem #(.ADDR_W(ADDR_W), .LATENCY(15)) dut_l15 (
        .clk(clk), .clrn(clrn), .req(req15), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy15), .ready(ready15), .rdata(rdata15), .err(err15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------ reference model
    function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
`ifdef MC_DATAMEM_MISALIGN_CHECK_EN
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_base(input logic [31:0] a, input logic [1:0] sz);
        int b;
        b = int'(a & c_amask);
        if (sz == 2'b01) b = b - (b % 2);
        if (sz[1])       b = b - (b % 4);
        return b;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        int b;
        logic [7:0]  v8;
        logic [15:0] v16;
        if (m_err(a, sz)) return 32'd0;
        b = m_base(a, sz);
        if (sz == 2'b00) begin
            v8 = mb[b];
            return u ? {24'd0, v8} : {{24{v8[7]}}, v8};
        end else if (sz == 2'b01) begin
            v16 = {mb[b+1], mb[b]};
            return u ? {16'd0, v16} : {{16{v16[15]}}, v16};
        end
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int b;
        if (m_err(a, sz)) return;
        b = m_base(a, sz);
        mb[b] = d[7:0];
        if (sz != 2'b00) mb[b+1] = d[15:8];
        if (sz[1]) begin
            mb[b+2] = d[23:16];
            mb[b+3] = d[31:24];
        end
    endtask

    // ---------------------------------------------- driver (no checking)
    // Call this with the DUT idle, 1 time unit after a rising edge. It
    // returns one cycle after the ready cycle, again 1 unit after an edge.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output logic [31:0] rd, output logic e,
                             output logic bsy, output logic rdy_after);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        lat = 1;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ready) lat = 99;
        rd = rdata; e = err; bsy = busy;
        @(posedge clk); #1;
        rdy_after = ready;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        clrn = 1'b0; req = 1'b0; req1 = 1'b0; req15 = 1'b0;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (ready !== 1'b0)  begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_vec++; if (err !== 1'b0)    begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        clrn = 1'b1;
    endtask

    task automatic test_sw_lw();
        int lat; logic [31:0] rd; logic e, bsy, ra;
        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, e, bsy, ra);
        m_store(32'h10, 2'b10, 32'hDEADBEEF);
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT); end
        n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL sw_rdata: got %h want 0", rd); end
        n_vec++; if (bsy !== 1'b1) begin n_err++; $display("FAIL sw_busy_at_ready: got %b want 1", bsy); end
        n_vec++; if (ra !== 1'b0)  begin n_err++; $display("FAIL sw_ready_width: got %b want 0", ra); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sw_busy_after: got %b want 0", busy); end
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL lw_latency: got %0d want %0d", lat, LAT); end
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL lw_err: got %b want 0", e); end
    endtask

    task automatic test_byte_half();
        int lat; logic [31:0] rd; logic e, bsy, ra;
        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, e, bsy, ra);
        m_store(32'h10, 2'b10, 32'h0);
        do_access(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, lat, rd, e, bsy, ra);
        m_store(32'h13, 2'b00, 32'h80);
        do_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (rd !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_sign: got %h want ffffff80", rd); end
        do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (rd !== 32'h00000080) begin n_err++; $display("FAIL lbu_zero: got %h want 00000080", rd); end
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (rd !== 32'h80000000) begin n_err++; $display("FAIL lw_after_sb: got %h want 80000000", rd); end
        do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234, lat, rd, e, bsy, ra);
        m_store(32'h22, 2'b01, 32'h1234);
        do_access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (rd !== 32'h00001234) begin n_err++; $display("FAIL lh_pos: got %h want 00001234", rd); end
        do_access(1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF8001, lat, rd, e, bsy, ra);
        m_store(32'h20, 2'b01, 32'hFFFF8001);
        do_access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (rd !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_neg: got %h want ffff8001", rd); end
        do_access(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (rd !== 32'h00008001) begin n_err++; $display("FAIL lhu: got %h want 00008001", rd); end
        do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (rd !== 32'h12348001) begin n_err++; $display("FAIL lw_two_halves: got %h want 12348001", rd); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd, exp_rd; logic e, bsy, ra, exp_e;
        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, e, bsy, ra);
        m_store(32'h10, 2'b10, 32'h11223344);
        do_access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat, rd, e, bsy, ra);
`ifdef MC_DATAMEM_MISALIGN_CHECK_EN
        exp_rd = 32'd0;       exp_e = 1'b1;
`else
        exp_rd = 32'h11223344; exp_e = 1'b0;
`endif
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL mis_latency: got %0d want %0d", lat, LAT); end
        n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL mis_lw_rdata: got %h want %h", rd, exp_rd); end
        n_vec++; if (e !== exp_e) begin n_err++; $display("FAIL mis_lw_err: got %b want %b", e, exp_e); end
        do_access(1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFFFFFF, lat, rd, e, bsy, ra);
        n_vec++; if (e !== exp_e) begin n_err++; $display("FAIL mis_sw_err: got %b want %b", e, exp_e); end
        m_store(32'h11, 2'b10, 32'hFFFFFFFF);
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, e, bsy, ra);
`ifdef MC_DATAMEM_MISALIGN_CHECK_EN
        exp_rd = 32'h11223344;
`else
        exp_rd = 32'hFFFFFFFF;
`endif
        n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL mis_sw_effect: got %h want %h", rd, exp_rd); end
        do_access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat, rd, e, bsy, ra);
        exp_rd = m_load(32'h13, 2'b01, 1'b0);
        n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL mis_lh: got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_back_to_back();
        int last [3];
        int cnt  [3];
        int lats [3];
        int exp_cnt;
        logic rv [3];
        lats[0] = LAT; lats[1] = 1; lats[2] = 15;
        for (int j = 0; j < 3; j++) begin last[j] = 0; cnt[j] = 0; end
        req = 1'b1; req1 = 1'b1; req15 = 1'b1;
        we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10; wdata = 32'd0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            rv[0] = ready; rv[1] = ready1; rv[2] = ready15;
            for (int j = 0; j < 3; j++) begin
                if (rv[j]) begin
                    n_vec++;
                    if (cnt[j] == 0) begin
                        if (k !== lats[j]) begin n_err++; $display("FAIL b2b_first_L%0d: got cycle %0d want %0d", lats[j], k, lats[j]); end
                    end else if ((k - last[j]) !== lats[j] + 1) begin
                        n_err++; $display("FAIL b2b_spacing_L%0d: got %0d want %0d", lats[j], k - last[j], lats[j] + 1);
                    end
                    cnt[j]++;
                    last[j] = k;
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            exp_cnt = (70 - lats[j]) / (lats[j] + 1) + 1;
            n_vec++;
            if (cnt[j] !== exp_cnt) begin n_err++; $display("FAIL b2b_count_L%0d: got %0d want %0d", lats[j], cnt[j], exp_cnt); end
        end
        req = 1'b0; req1 = 1'b0; req15 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd; logic e, bsy, ra;
        int seen;
        do_access(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, lat, rd, e, bsy, ra);
        m_store(32'h40, 2'b10, 32'hCAFEF00D);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h0BADBEEF;
        @(posedge clk); #1;
        req = 1'b0;
        clrn = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_async: got %b want 0", busy); end
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL abort_ready_async: got %b want 0", ready); end
        @(posedge clk); #1;
        clrn = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_ready: got %0d readies want 0", seen); end
        do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, e, bsy, ra);
        n_vec++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL abort_no_commit: got %h want cafef00d", rd); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, a, d, exp_rd; logic e, bsy, ra, w, u, exp_e;
        logic [1:0] sz;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            do_access(1'b1, 2'b10, 1'b0, 32'(i * 4), d, lat, rd, e, bsy, ra);
            m_store(32'(i * 4), 2'b10, d);
        end
        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom);
            sz = 2'($urandom);
            u  = 1'($urandom);
            d  = $urandom;
            a  = ($urandom & ~c_amask) | 32'($urandom_range(0, 255));
            exp_e  = m_err(a, sz);
            exp_rd = w ? 32'd0 : m_load(a, sz, u);
            do_access(w, sz, u, a, d, lat, rd, e, bsy, ra);
            if (w) m_store(a, sz, d);
            n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL rnd_rdata[%0d] we=%b sz=%b uns=%b a=%h: got %h want %h", i, w, sz, u, a, rd, exp_rd); end
            n_vec++; if (e !== exp_e) begin n_err++; $display("FAIL rnd_err[%0d] a=%h sz=%b: got %b want %b", i, a, sz, e, exp_e); end
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte_half();
        test_misalign();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
